rsa_modmul: RTL

Sequential interleaved modular multiplier computing (a * b) mod n, one multiplier bit per clock, with no wide multiplier or divider. It sits directly under the RSA exponentiation controller. The controller issues one square or multiply per request and consumes the reduced product, replacing the single-cycle `*` / `%` datapath. A start/done handshake lets the exponentiation FSM wait on each product.

---
 rtl/rsa_modmul.sv | 91 +++++++++
 1 files changed

// File: rtl/rsa_modmul.sv
// rsa_modmul: interleaved shift-and-reduce modular multiplier, (a * b) mod n,
// one multiplier bit per clock, MSB first, with a start/done handshake.
module rsa_modmul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] product
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t state, state_nxt;
    logic [WIDTH-1:0] ra, rb, rn, p, p_nxt;
    logic [CW-1:0] cnt;
    logic bad, accept, last;
    logic [WIDTH+1:0] t, n1, n2, sub, d;

    // P < n and a < n keep T below 3n, so at most one of n or 2n is removed
    always_comb begin
        accept = state == IDLE && start;
        last = cnt == '0;
        n1 = {2'b00, rn};
        n2 = {1'b0, rn, 1'b0};
        t = {1'b0, p, 1'b0} + (rb[cnt] ? {2'b00, ra} : '0);
        sub = t >= n2 ? n2 : t >= n1 ? n1 : '0;
        d = t - sub;
        p_nxt = d[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (start ? (a >= n ? FINISH : RUN) : IDLE)
                  : state == RUN  ? (last ? FINISH : RUN)
                  : IDLE;
    end

    always_comb begin
        busy = state != IDLE;
    end

    // A rejected operand pair spends its one busy cycle in FINISH and reports on the way out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra <= '0;
            rb <= '0;
            rn <= '0;
            p <= '0;
            cnt <= '0;
            bad <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ra <= a;
                rb <= b;
                rn <= n;
                p <= '0;
                bad <= a >= n;
                cnt <= CNT_TOP;
            end else if (state == RUN) begin
                p <= p_nxt;
                cnt <= cnt - CW'(1);
                if (last) begin
                    done <= 1'b1;
                    err <= 1'b0;
                    product <= p_nxt;
                end
            end else if (state == FINISH && bad) begin
                done <= 1'b1;
                err <= 1'b1;
                product <= '0;
            end
        end
    end
endmodule
